// File: rtl/oflow_registration_id_tracker.sv
// Registration ID tracker: per-lane minimum-score search over previous-frame rows,
// followed by threshold matching and fresh-ID allocation, one lane per cycle.
module oflow_registration_id_tracker #(
    parameter int unsigned NUM_PE    = 2,
    parameter int unsigned SCORE_LEN = 16,
    parameter int unsigned ID_LEN    = 7,
    parameter int unsigned MAX_ROWS  = 32,
    parameter int unsigned FRAME_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset_N,
    input  logic                        start_registration,
    input  logic [FRAME_W-1:0]          frame_num,
    input  logic [$clog2(MAX_ROWS):0]   num_of_prev,
    input  logic [NUM_PE-1:0]           lane_en,
    input  logic [SCORE_LEN-1:0]        score_threshold,
    input  logic                        score_valid,
    input  logic [NUM_PE*SCORE_LEN-1:0] score_in,
    input  logic [ID_LEN-1:0]           prev_id_in,
    output logic                        busy,
    output logic                        done_registration,
    output logic [NUM_PE*ID_LEN-1:0]    id_out,
    output logic [NUM_PE*SCORE_LEN-1:0] best_score_out,
    output logic [NUM_PE-1:0]           matched,
    output logic [NUM_PE-1:0]           conflict
);
    localparam int unsigned CW  = $clog2(MAX_ROWS) + 1;
    localparam int unsigned LIW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, RESOLVE, DONE} state_t;

    state_t               state_q;
    logic [FRAME_W-1:0]   frame_q;
    logic [CW-1:0]        nprev_q;
    logic [CW-1:0]        beat_q;
    logic [NUM_PE-1:0]    lane_en_q;
    logic [SCORE_LEN-1:0] thr_q;
    logic [SCORE_LEN-1:0] best_score_q [NUM_PE];
    logic [ID_LEN-1:0]    best_id_q    [NUM_PE];
    logic [SCORE_LEN-1:0] bs_out_q     [NUM_PE];
    logic [ID_LEN-1:0]    id_q         [NUM_PE];
    logic [NUM_PE-1:0]    matched_q;
    logic [NUM_PE-1:0]    conflict_q;
    logic                 done_q;
    logic [ID_LEN-1:0]    newid_q;
    logic [LIW-1:0]       lane_q;

    logic [SCORE_LEN-1:0] sel_score;
    logic [ID_LEN-1:0]    sel_id;
    logic [ID_LEN-1:0]    newid_d;
    logic                 cand;
    logic                 dup;

    // Resolution of the lane currently addressed by lane_q; lower lanes are already final.
    always_comb begin
        sel_score = best_score_q[lane_q];
        sel_id    = best_id_q[lane_q];
        cand      = lane_en_q[lane_q] && (frame_q != '0) && (sel_id != '0)
                    && (sel_score < thr_q);
        dup       = 1'b0;
        for (int unsigned j = 0; j < NUM_PE; j++) begin
            if ((LIW'(j) < lane_q) && matched_q[j] && (id_q[j] == sel_id)) dup = 1'b1;
        end
        newid_d   = (newid_q == '1) ? ID_LEN'(1) : newid_q + ID_LEN'(1);
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            nprev_q    <= '0;
            beat_q     <= '0;
            lane_en_q  <= '0;
            thr_q      <= '0;
            matched_q  <= '0;
            conflict_q <= '0;
            done_q     <= 1'b0;
            newid_q    <= ID_LEN'(1);
            lane_q     <= '0;
            for (int unsigned i = 0; i < NUM_PE; i++) begin
                best_score_q[i] <= '1;
                best_id_q[i]    <= '0;
                bs_out_q[i]     <= '0;
                id_q[i]         <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // done_q marks the pulse cycle, which still belongs to the finishing run.
                    if (start_registration && !done_q) begin
                        frame_q    <= frame_num;
                        nprev_q    <= num_of_prev;
                        lane_en_q  <= lane_en;
                        thr_q      <= score_threshold;
                        beat_q     <= '0;
                        lane_q     <= '0;
                        matched_q  <= '0;
                        conflict_q <= '0;
                        for (int unsigned i = 0; i < NUM_PE; i++) begin
                            best_score_q[i] <= '1;
                            best_id_q[i]    <= '0;
                            id_q[i]         <= '0;
                        end
                        state_q <= ((frame_num == '0) || (num_of_prev == '0)) ? RESOLVE : COMPARE;
                    end
                end
                COMPARE: begin
                    if (score_valid) begin
                        beat_q <= beat_q + CW'(1);
                        for (int unsigned i = 0; i < NUM_PE; i++) begin
                            if (lane_en_q[i] && (prev_id_in != '0)
                                && (score_in[i*SCORE_LEN +: SCORE_LEN] < best_score_q[i])) begin
                                best_score_q[i] <= score_in[i*SCORE_LEN +: SCORE_LEN];
                                best_id_q[i]    <= prev_id_in;
                            end
                        end
                        if (beat_q + CW'(1) == nprev_q) state_q <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    bs_out_q[lane_q] <= sel_score;
                    if (!lane_en_q[lane_q]) begin
                        id_q[lane_q] <= '0;
                    end else if (cand && !dup) begin
                        id_q[lane_q]      <= sel_id;
                        matched_q[lane_q] <= 1'b1;
                    end else begin
                        id_q[lane_q]       <= newid_q;
                        newid_q            <= newid_d;
                        conflict_q[lane_q] <= cand;
                    end
                    if (lane_q == LIW'(NUM_PE - 1)) state_q <= DONE;
                    else lane_q <= lane_q + LIW'(1);
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        id_out         = '0;
        best_score_out = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            id_out[i*ID_LEN +: ID_LEN]            = id_q[i];
            best_score_out[i*SCORE_LEN +: SCORE_LEN] = bs_out_q[i];
        end
    end

    assign busy              = (state_q != IDLE);
    assign done_registration = done_q;
    assign matched           = matched_q;
    assign conflict          = conflict_q;

endmodule

// File: tb/tb_oflow_registration_id_tracker.sv
// Randomised bench for oflow_registration_id_tracker: a transaction-level model predicts
// per-run results and done timing; a per-cycle monitor compares the DUT against it.
module tb_oflow_registration_id_tracker;
    localparam int NP  = 2;
    localparam int SL  = 16;
    localparam int IL  = 7;
    localparam int MR  = 32;
    localparam int FW  = 8;
    localparam int CW  = 6;
    localparam int INF = 1 << 30;

    logic              clk = 1'b0;
    logic              reset_N = 1'b0;
    logic              start_registration = 1'b0;
    logic [FW-1:0]     frame_num = '0;
    logic [CW-1:0]     num_of_prev = '0;
    logic [NP-1:0]     lane_en = '0;
    logic [SL-1:0]     score_threshold = '0;
    logic              score_valid = 1'b0;
    logic [NP*SL-1:0]  score_in = '0;
    logic [IL-1:0]     prev_id_in = '0;
    logic              busy;
    logic              done_registration;
    logic [NP*IL-1:0]  id_out;
    logic [NP*SL-1:0]  best_score_out;
    logic [NP-1:0]     matched;
    logic [NP-1:0]     conflict;

    always #5 clk = ~clk;

    oflow_registration_id_tracker #(
        .NUM_PE(NP), .SCORE_LEN(SL), .ID_LEN(IL), .MAX_ROWS(MR), .FRAME_W(FW)
    ) dut (
        .clk(clk), .reset_N(reset_N), .start_registration(start_registration),
        .frame_num(frame_num), .num_of_prev(num_of_prev), .lane_en(lane_en),
        .score_threshold(score_threshold), .score_valid(score_valid), .score_in(score_in),
        .prev_id_in(prev_id_in), .busy(busy), .done_registration(done_registration),
        .id_out(id_out), .best_score_out(best_score_out), .matched(matched),
        .conflict(conflict)
    );

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int s_edge = INF;
    int d_edge = INF;
    int last_done_edge = 0;
    int last_beat_edge = 0;
    int m_ctr = 1;

    // Held results (before the current start) and results of the current run.
    logic [NP*IL-1:0] h_id = '0, n_id = '0;
    logic [NP-1:0]    h_m = '0, n_m = '0, h_c = '0, n_c = '0;
    logic [NP*SL-1:0] h_bs = '0, n_bs = '0, h_msk = '1, n_msk = '1;

    int unsigned r_id [MR];
    int unsigned r_sc [MR][NP];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endfunction

    logic             e_busy, e_done, use_new;
    always @(posedge clk) begin
        edge_n++;
        #1;
        e_busy = (edge_n >= s_edge) && (edge_n < d_edge);
        e_done = (edge_n == d_edge);
        if (done_registration) last_done_edge = edge_n;
        chk("busy", busy, e_busy);
        chk("done_registration", done_registration, e_done);
        if (!e_busy) begin
            use_new = (edge_n >= d_edge);
            chk("id_out", id_out, use_new ? n_id : h_id);
            chk("matched", matched, use_new ? n_m : h_m);
            chk("conflict", conflict, use_new ? n_c : h_c);
            chk("best_score_out", best_score_out & (use_new ? n_msk : h_msk),
                use_new ? (n_bs & n_msk) : (h_bs & h_msk));
        end
    end

    task automatic do_reset();
        reset_N = 1'b0;
        start_registration = 1'b0;
        score_valid = 1'b0;
        h_id = '0; n_id = '0; h_m = '0; n_m = '0; h_c = '0; n_c = '0;
        h_bs = '0; n_bs = '0; h_msk = '1; n_msk = '1;
        s_edge = INF; d_edge = INF; m_ctr = 1;
        @(negedge clk);
        reset_N = 1'b1;
    endtask

    // Expected results from the rows table: minimum score per lane, then ascending resolution.
    task automatic model(input int fr, input int np, input int en, input int thr);
        int  bs [NP];
        int  bid [NP];
        bit  cand, taken;
        for (int i = 0; i < NP; i++) begin
            bs[i] = (1 << SL) - 1;
            bid[i] = 0;
            if (en[i] && fr != 0)
                for (int b = 0; b < np; b++)
                    if (r_id[b] != 0 && int'(r_sc[b][i]) < bs[i]) begin
                        bs[i] = int'(r_sc[b][i]);
                        bid[i] = int'(r_id[b]);
                    end
        end
        n_id = '0; n_m = '0; n_c = '0; n_bs = '0; n_msk = '0;
        for (int i = 0; i < NP; i++) begin
            n_bs[i*SL +: SL] = bs[i][SL-1:0];
            if (en[i]) begin
                n_msk[i*SL +: SL] = '1;
                cand = (fr != 0) && (bid[i] != 0) && (bs[i] < thr);
                taken = 1'b0;
                for (int j = 0; j < i; j++)
                    if (n_m[j] && int'(n_id[j*IL +: IL]) == bid[i]) taken = 1'b1;
                if (cand && !taken) begin
                    n_id[i*IL +: IL] = bid[i][IL-1:0];
                    n_m[i] = 1'b1;
                end else begin
                    n_id[i*IL +: IL] = m_ctr[IL-1:0];
                    m_ctr = m_ctr % ((1 << IL) - 1) + 1;
                    n_c[i] = cand;
                end
            end
        end
    endtask

    task automatic run(input int fr, input int np, input int en, input int thr, input int abort_at);
        int b;
        @(negedge clk);
        h_id = n_id; h_m = n_m; h_c = n_c; h_bs = n_bs; h_msk = n_msk;
        model(fr, np, en, thr);
        s_edge = edge_n + 1;
        start_registration = 1'b1;
        frame_num = fr[FW-1:0];
        num_of_prev = np[CW-1:0];
        lane_en = en[NP-1:0];
        score_threshold = thr[SL-1:0];
        score_valid = 1'b0;
        d_edge = (fr == 0 || np == 0) ? s_edge + NP + 1 : INF;
        if (fr != 0 && np != 0) begin
            b = 0;
            while (b < np) begin
                @(negedge clk);
                start_registration = 1'b0;
                if (abort_at == b) begin
                    do_reset();
                    return;
                end
                for (int i = 0; i < NP; i++) score_in[i*SL +: SL] = SL'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    // idle slot, optionally with a stray start that must be ignored
                    score_valid = 1'b0;
                    prev_id_in = IL'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        start_registration = 1'b1;
                        frame_num = FW'($urandom);
                        lane_en = NP'($urandom);
                    end
                end else begin
                    score_valid = 1'b1;
                    prev_id_in = r_id[b][IL-1:0];
                    for (int i = 0; i < NP; i++) score_in[i*SL +: SL] = r_sc[b][i][SL-1:0];
                    if (b == np - 1) begin
                        last_beat_edge = edge_n + 1;
                        d_edge = edge_n + 1 + NP + 1;
                    end
                    b++;
                end
            end
        end
        @(negedge clk);
        while (edge_n < d_edge + 1) begin
            score_valid = 1'($urandom);
            start_registration = (edge_n < d_edge) ? 1'($urandom) : 1'b0;
            frame_num = FW'($urandom);
            @(negedge clk);
        end
        start_registration = 1'b0;
        score_valid = 1'b0;
    endtask

    task automatic set_row(input int b, input int id, input int s0, input int s1);
        r_id[b] = id;
        r_sc[b][0] = s0;
        r_sc[b][1] = s1;
    endtask

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_N = 1'b1;
        chk("reset_busy", busy, 0);
        chk("reset_id_out", id_out, 0);

        run(0, 0, 3, 0, -1);
        chk("f0_ids", id_out, {7'd2, 7'd1});
        chk("f0_matched", matched, 0);
        chk("f0_latency", last_done_edge - s_edge, 3);

        set_row(0, 1, 10, 500);
        set_row(1, 2, 400, 20);
        run(1, 2, 3, 100, -1);
        chk("f1_ids", id_out, {7'd2, 7'd1});
        chk("f1_matched", matched, 2'b11);
        chk("f1_best", best_score_out, {16'd20, 16'd10});

        run(2, 2, 3, 15, -1);
        chk("thr_ids", id_out, {7'd3, 7'd1});
        chk("thr_matched", matched, 2'b01);
        chk("thr_best1", best_score_out[SL +: SL], 20);

        set_row(0, 1, 5, 6);
        run(3, 1, 3, 100, -1);
        chk("dup_ids", id_out, {7'd4, 7'd1});
        chk("dup_conflict", conflict, 2'b10);
        chk("dup_matched", matched, 2'b01);

        set_row(0, 0, 0, 0);
        set_row(1, 3, 50, 7);
        run(4, 2, 1, 100, -1);
        chk("mask_ids", id_out, {7'd0, 7'd3});
        chk("mask_matched", matched, 2'b01);
        chk("mask_latency", last_done_edge - last_beat_edge, 3);

        for (int b = 0; b < 5; b++) set_row(b, b + 1, 10 * b, 20 * b);
        run(5, 5, 3, 100, 2);
        run(0, 0, 3, 0, -1);
        chk("after_abort_ids", id_out, {7'd2, 7'd1});

        @(negedge clk);
        do_reset();
        for (int k = 0; k < 125; k++) run(0, 0, 1, 0, -1);
        run(0, 0, 3, 0, -1);
        chk("wrap_ids", id_out, {7'd127, 7'd126});
        run(0, 0, 1, 0, -1);
        chk("wrap_to_1", id_out, {7'd0, 7'd1});

        for (int k = 0; k < 150; k++) begin
            int fr, np;
            fr = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            np = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, MR));
            for (int b = 0; b < np; b++) begin
                r_id[b] = $urandom_range(0, 6);
                for (int i = 0; i < NP; i++)
                    r_sc[b][i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535)
                                                             : $urandom_range(0, 300);
            end
            run(fr, np, int'($urandom_range(0, 3)), int'($urandom_range(0, 400)),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
